// File: rtl/counter_second_if.sv
// counter_second_if: control/status bundle between the seconds counter and its driver.
interface counter_second_if;
  logic       en;
  logic [6:0] set_numb_sec;
  logic       load;
  logic [6:0] load_val;
  logic       sec_tick;
  logic       minute_clk;
  logic [6:0] second_w;
  modport master (output en, set_numb_sec, load, load_val, input sec_tick, minute_clk, second_w);
  modport slave (input en, set_numb_sec, load, load_val, output sec_tick, minute_clk, second_w);
endinterface

// File: rtl/counter_second.sv
// counter_second: divides clk into one-second ticks, counts 0..lim, strobes minute_clk on wrap.
module counter_second #(
  parameter int unsigned CLK_DIV = 50_000_000,
  parameter int unsigned DIV_W = 32
) (
  input logic clk,
  input logic rst,
  counter_second_if.slave bus
);
  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [6:0] sec_q, sec_d, lim, load_sat;
  logic tick_q, tick_d, min_q, min_d, term, wrap;
  assign lim = (bus.set_numb_sec >= 7'd1 && bus.set_numb_sec <= 7'd59) ? bus.set_numb_sec : 7'd59;
  assign load_sat = bus.load_val > lim ? lim : bus.load_val;
  assign term = presc_q == TERM;
  assign wrap = sec_q >= lim;
  // priority: disable > load > tick > idle; strobes are only ever set by a real tick
  always_comb begin
    presc_d = (!bus.en || bus.load || term) ? '0 : presc_q + 1'b1;
    sec_d = !bus.en ? 7'd0 : bus.load ? load_sat : term ? (wrap ? 7'd0 : sec_q + 7'd1) : sec_q;
    tick_d = bus.en && !bus.load && term;
    min_d = tick_d && wrap;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      presc_q <= '0;
      sec_q <= '0;
      tick_q <= 1'b0;
      min_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q <= sec_d;
      tick_q <= tick_d;
      min_q <= min_d;
    end
  assign bus.sec_tick = tick_q;
  assign bus.minute_clk = min_q;
  assign bus.second_w = sec_q;
endmodule

// File: tb/tb_counter_second.sv
// tb_counter_second: directed checks of the seconds counter with CLK_DIV=4.
module tb_counter_second;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0, fails = 0;
  int n_tick, n_min, max_sec;
  counter_second_if bus ();
  counter_second #(.CLK_DIV(4), .DIV_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic run(input int n);
    n_tick = 0;
    n_min = 0;
    max_sec = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      n_tick += int'(bus.sec_tick);
      n_min += int'(bus.minute_clk);
      if (int'(bus.second_w) > max_sec) max_sec = int'(bus.second_w);
      if (bus.minute_clk === 1'b1) chk("wrap_sec_zero", int'(bus.second_w), 0);
    end
  endtask
  task automatic do_load(input logic [6:0] v);
    bus.load = 1'b1;
    bus.load_val = v;
    cyc(1);
    bus.load = 1'b0;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.set_numb_sec = 7'd0;
    bus.load = 1'b0;
    bus.load_val = 7'd0;
    cyc(2);
    chk("rst_sec", int'(bus.second_w), 0);
    chk("rst_tick", int'(bus.sec_tick), 0);
    chk("rst_min", int'(bus.minute_clk), 0);
    rst = 1'b1;
    bus.en = 1'b1;
    cyc(3);
    chk("first_no_tick", int'(bus.sec_tick), 0);
    chk("first_sec0", int'(bus.second_w), 0);
    cyc(1);
    chk("first_tick", int'(bus.sec_tick), 1);
    chk("first_sec1", int'(bus.second_w), 1);
    cyc(1);
    chk("tick_one_cycle", int'(bus.sec_tick), 0);
    do_load(7'd17);
    chk("load17", int'(bus.second_w), 17);
    chk("load17_tick", int'(bus.sec_tick), 0);
    cyc(2);
    rst = 1'b0;
    #1;
    chk("async_rst_sec", int'(bus.second_w), 0);
    chk("async_rst_tick", int'(bus.sec_tick), 0);
    chk("async_rst_min", int'(bus.minute_clk), 0);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    chk("post_rst_no_tick", int'(bus.sec_tick), 0);
    cyc(1);
    chk("post_rst_tick", int'(bus.sec_tick), 1);
    chk("post_rst_sec", int'(bus.second_w), 1);
    bus.en = 1'b0;
    cyc(1);
    bus.en = 1'b1;
    run(240);
    chk("wrap59_ticks", n_tick, 60);
    chk("wrap59_mins", n_min, 1);
    chk("wrap59_max", max_sec, 59);
    chk("wrap59_end_min", int'(bus.minute_clk), 1);
    chk("wrap59_end_sec", int'(bus.second_w), 0);
    bus.set_numb_sec = 7'd9;
    run(40);
    chk("lim9_ticks", n_tick, 10);
    chk("lim9_mins", n_min, 1);
    chk("lim9_max", max_sec, 9);
    chk("lim9_end_min", int'(bus.minute_clk), 1);
    bus.set_numb_sec = 7'd75;
    run(240);
    chk("lim75_mins", n_min, 1);
    chk("lim75_max", max_sec, 59);
    do_load(7'd58);
    chk("load58_sec", int'(bus.second_w), 58);
    chk("load58_tick", int'(bus.sec_tick), 0);
    chk("load58_min", int'(bus.minute_clk), 0);
    cyc(4);
    chk("after58_sec", int'(bus.second_w), 59);
    chk("after58_min", int'(bus.minute_clk), 0);
    cyc(4);
    chk("after59_sec", int'(bus.second_w), 0);
    chk("after59_min", int'(bus.minute_clk), 1);
    bus.set_numb_sec = 7'd9;
    do_load(7'd20);
    chk("load_sat_lim9", int'(bus.second_w), 9);
    bus.set_numb_sec = 7'd0;
    do_load(7'd70);
    chk("load_sat_59", int'(bus.second_w), 59);
    cyc(3);
    chk("coll_pre_sec", int'(bus.second_w), 59);
    do_load(7'd5);
    chk("coll_sec", int'(bus.second_w), 5);
    chk("coll_tick", int'(bus.sec_tick), 0);
    chk("coll_min", int'(bus.minute_clk), 0);
    cyc(3);
    chk("coll_no_tick", int'(bus.sec_tick), 0);
    cyc(1);
    chk("coll_next_tick", int'(bus.sec_tick), 1);
    chk("coll_next_sec", int'(bus.second_w), 6);
    do_load(7'd25);
    cyc(2);
    bus.en = 1'b0;
    cyc(1);
    chk("endrop_sec", int'(bus.second_w), 0);
    cyc(2);
    chk("endrop_tick", int'(bus.sec_tick), 0);
    bus.en = 1'b1;
    cyc(3);
    chk("enup_no_tick", int'(bus.sec_tick), 0);
    cyc(1);
    chk("enup_tick", int'(bus.sec_tick), 1);
    chk("enup_sec", int'(bus.second_w), 1);
    do_load(7'd40);
    bus.set_numb_sec = 7'd30;
    cyc(4);
    chk("lower_lim_sec", int'(bus.second_w), 0);
    chk("lower_lim_min", int'(bus.minute_clk), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
